q_fetch_max: RTL and testbench

- Upstream stage of the Q-update datapath. For one transition (s, a, s'), fetches Q[s][a] from the Q-table RAM, then scans Q[s'][0..NUM_ACTIONS-1].
- Presents q_current, q_next_max and the argmax action with a valid/ready handshake.
- Sequential FSM driving a synchronous-read memory port. Outputs feed the q_current and q_next_max inputs of the update datapath directly.

---
 rtl/q_learning_pkg.sv | 20 ++
 rtl/q_max_tracker.sv | 41 ++++
 rtl/q_fetch_max.sv | 151 +++++++++++++++
 tb/tb_q_fetch_max.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/q_learning_pkg.sv
// q_learning_pkg: shared types and defaults for the Q-learning datapath.
//   Q_DATA_WIDTH / Q_NUM_ACTIONS / Q_NUM_STATES : default table geometry.
//   fetch_state_t : state encoding of the Q-value fetch FSM.
//   q_value_t     : signed fixed-point Q value, shared with the update stage.
package q_learning_pkg;

  localparam int Q_DATA_WIDTH  = 32;
  localparam int Q_NUM_ACTIONS = 4;
  localparam int Q_NUM_STATES  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  typedef logic signed [Q_DATA_WIDTH-1:0] q_value_t;

endpackage

// File: rtl/q_max_tracker.sv
// q_max_tracker: registered running signed maximum with its argmax.
//   clk, rst : clock, synchronous active-high reset (clears max/arg to 0)
//   init     : load (value, index) unconditionally
//   update   : load (value, index) only if value > max (strictly), so ties
//              keep the earliest index seen
//   value    : signed candidate value
//   index    : index associated with value
//   max, arg : current maximum and its index
module q_max_tracker #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  input  logic                         update,
  input  logic signed [DATA_WIDTH-1:0] value,
  input  logic        [IDX_W-1:0]      index,
  output logic signed [DATA_WIDTH-1:0] max,
  output logic        [IDX_W-1:0]      arg
);

  function automatic logic is_greater(input logic signed [DATA_WIDTH-1:0] a,
                                      input logic signed [DATA_WIDTH-1:0] b);
    return a > b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      max <= '0;
      arg <= '0;
    end else if (init) begin
      max <= value;
      arg <= index;
    end else if (update && is_greater(value, max)) begin
      max <= value;
      arg <= index;
    end
  end

endmodule

// File: rtl/q_fetch_max.sv
// q_fetch_max: fetches Q[s][a] and max/argmax over Q[s'][*] from a
// synchronous-read Q-table for one transition (s, a, s').
//   clk, rst                    : clock, synchronous active-high reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_state/action/next_state : transition (s, a, s')
//   req_terminal                : only with Q_FETCH_TERMINAL_EN; skips the
//                                 scan of s' and reports next max = 0
//   mem_rd_en, mem_addr         : read port, addr = {state, action}, 0 when idle
//   mem_rdata                   : read data, valid one cycle after the read
//   out_valid/out_ready         : result handshake, outputs held while stalled
//   out_q_current               : Q[s][a]
//   out_q_next_max              : max over Q[s'][*]
//   out_best_action             : lowest action index achieving that max
//   busy                        : FSM is not in IDLE
// Configuration macro: Q_FETCH_TERMINAL_EN (adds req_terminal).
module q_fetch_max
  import q_learning_pkg::*;
#(
  parameter  int DATA_WIDTH  = Q_DATA_WIDTH,
  parameter  int NUM_ACTIONS = Q_NUM_ACTIONS,
  parameter  int NUM_STATES  = Q_NUM_STATES,
  localparam int ACT_W       = $clog2(NUM_ACTIONS),
  localparam int ST_W        = $clog2(NUM_STATES),
  localparam int ADDR_W      = ST_W + ACT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic        [ST_W-1:0]       req_state,
  input  logic        [ACT_W-1:0]      req_action,
  input  logic        [ST_W-1:0]       req_next_state,
`ifdef Q_FETCH_TERMINAL_EN
  input  logic                         req_terminal,
`endif
  output logic                         mem_rd_en,
  output logic        [ADDR_W-1:0]     mem_addr,
  input  logic signed [DATA_WIDTH-1:0] mem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_q_current,
  output logic signed [DATA_WIDTH-1:0] out_q_next_max,
  output logic        [ACT_W-1:0]      out_best_action,
  output logic                         busy
);

  // cnt must reach NUM_ACTIONS, hence one extra bit over the action index.
  localparam int CNT_W = ACT_W + 1;

  fetch_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [ST_W-1:0]  next_state_p0;
  logic             accept;
  logic             last_read;

  // Read-return tracking: which read's data is on mem_rdata this cycle.
  logic             vld_p1;
  logic [CNT_W-1:0] idx_p1;

  logic                         trk_init;
  logic                         trk_update;
  logic signed [DATA_WIDTH-1:0] trk_value;
  logic        [ACT_W-1:0]      trk_index;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign req_ready = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

`ifdef Q_FETCH_TERMINAL_EN
  logic terminal_p0;

  always_ff @(posedge clk) begin
    if (accept) terminal_p0 <= req_terminal;
  end

  // A terminal transition has no successor value: stop after the Q[s][a] read.
  assign last_read = (cnt == CNT_W'(NUM_ACTIONS)) || (terminal_p0 && (cnt == '0));
`else
  assign last_read = (cnt == CNT_W'(NUM_ACTIONS));
`endif

  always_ff @(posedge clk) begin
    if (accept) next_state_p0 <= req_next_state;
  end

  // Stage p0: FSM and read issue
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      mem_rd_en     <= 1'b0;
      mem_addr      <= '0;
      vld_p1        <= 1'b0;
      idx_p1        <= '0;
      out_q_current <= '0;
    end else begin
      vld_p1 <= (state == ST_ISSUE);
      idx_p1 <= cnt;
      if (vld_p1 && (idx_p1 == '0)) out_q_current <= mem_rdata;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cnt       <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= {req_state, req_action};
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt <= cnt + CNT_W'(1);
          if (last_read) begin
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            state     <= ST_DRAIN;
          end else begin
            // cnt=k is being read now; the next read is action k of s'.
            mem_rd_en <= 1'b1;
            mem_addr  <= {next_state_p0, cnt[ACT_W-1:0]};
          end
        end
        ST_DRAIN: state <= ST_DONE;
        ST_DONE:  if (out_ready) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Stage p1: read data return into the max tracker
  // Clearing at accept leaves max/arg at 0 when no scan reads arrive.
  assign trk_init   = accept || (vld_p1 && (idx_p1 == CNT_W'(1)));
  assign trk_update = vld_p1 && (idx_p1 > CNT_W'(1));
  assign trk_value  = accept ? '0 : mem_rdata;
  assign trk_index  = accept ? '0 : ACT_W'(idx_p1[ACT_W-1:0] - ACT_W'(1));

  q_max_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (ACT_W)
  ) u_max (
    .clk    (clk),
    .rst    (rst),
    .init   (trk_init),
    .update (trk_update),
    .value  (trk_value),
    .index  (trk_index),
    .max    (out_q_next_max),
    .arg    (out_best_action)
  );

endmodule

// File: tb/tb_q_fetch_max.sv
module tb_q_fetch_max;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [3:0]         req_state;
  logic [1:0]         req_action;
  logic [3:0]         req_next_state;
`ifdef Q_FETCH_TERMINAL_EN
  logic               req_terminal;
`endif
  logic               mem_rd_en;
  logic [5:0]         mem_addr;
  logic signed [31:0] mem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_q_current;
  logic signed [31:0] out_q_next_max;
  logic [1:0]         out_best_action;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [31:0] qmem [0:63];

  always #5 clk = ~clk;

  // Synchronous-read Q-table model.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= qmem[mem_addr];
  end

  q_fetch_max dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_state       (req_state),
    .req_action      (req_action),
    .req_next_state  (req_next_state),
`ifdef Q_FETCH_TERMINAL_EN
    .req_terminal    (req_terminal),
`endif
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_q_current   (out_q_current),
    .out_q_next_max  (out_q_next_max),
    .out_best_action (out_best_action),
    .busy            (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request; returns #1 after the accepting edge.
  task automatic send(input int s, input int a, input int ns, input bit term);
    @(negedge clk);
    req_state      = 4'(s);
    req_action     = 2'(a);
    req_next_state = 4'(ns);
`ifdef Q_FETCH_TERMINAL_EN
    req_terminal   = term;
`else
    if (term) $display("terminal request ignored in this build");
`endif
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Count edges until out_valid (bounded), then check latency and results.
  task automatic wait_out(input string tag, input int lat,
                          input logic [31:0] cur, input logic [31:0] mx,
                          input logic [31:0] best);
    int edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({tag, "_latency"}, 32'(edges), 32'(lat));
    chk({tag, "_qcur"}, out_q_current, cur);
    chk({tag, "_qmax"}, out_q_next_max, mx);
    chk({tag, "_best"}, 32'(out_best_action), best);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) qmem[i] = '0;
    qmem[3*4+2] = 32'sd100;
    qmem[20] = 32'sd10;  qmem[21] = -32'sd7;  qmem[22] = 32'sd42; qmem[23] = 32'sd41;
    qmem[4]  = -32'sd5;  qmem[5]  = -32'sd5;  qmem[6]  = -32'sd9; qmem[7]  = -32'sd5;
    qmem[8]  = 32'h80000000; qmem[9]  = 32'h80000000;
    qmem[10] = 32'h80000000; qmem[11] = 32'h80000001;
    qmem[16] = 32'h7FFFFFFF; qmem[17] = 32'h80000000; qmem[18] = 32'sd0; qmem[19] = 32'h7FFFFFFE;
    qmem[24] = -32'sd1;
    qmem[0]  = 32'sd3;   qmem[1]  = 32'sd9;   qmem[2]  = -32'sd2;  qmem[3]  = 32'sd9;
    qmem[29] = -32'sd77;
    qmem[39] = 32'sd555;

    rst = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    req_state = '0; req_action = '0; req_next_state = '0;
`ifdef Q_FETCH_TERMINAL_EN
    req_terminal = 1'b0;
`endif
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_qcur", out_q_current, 32'd0);
    chk("rst_qmax", out_q_next_max, 32'd0);
    rst = 1'b0;

    // Basic scan.
    send(3, 2, 5, 1'b0);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_req_ready", 32'(req_ready), 32'd0);
    wait_out("basic", 6, 32'd100, 32'd42, 32'd2);
    handshake("basic");

    // Ties among negatives, s == s'.
    send(1, 0, 1, 1'b0);
    wait_out("ties", 6, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd0);
    handshake("ties");

    // Most-negative values.
    send(2, 3, 2, 1'b0);
    wait_out("minneg", 6, 32'h80000001, 32'h80000001, 32'd3);
    handshake("minneg");

    // Most-positive value at action 0.
    send(6, 0, 4, 1'b0);
    wait_out("maxpos", 6, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0);
    handshake("maxpos");

    // Backpressure: hold out_ready low for 10 cycles.
    send(3, 2, 5, 1'b0);
    wait_out("bp", 6, 32'd100, 32'd42, 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_qcur", out_q_current, 32'd100);
      chk("bp_qmax", out_q_next_max, 32'd42);
      chk("bp_best", 32'(out_best_action), 32'd2);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    handshake("bp");
    send(1, 0, 1, 1'b0);
    wait_out("b2b", 6, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd0);
    handshake("b2b");

    // Reset mid-scan at cnt=2.
    send(3, 2, 5, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("midrst_qcur", out_q_current, 32'd0);
    chk("midrst_qmax", out_q_next_max, 32'd0);
    chk("midrst_best", 32'(out_best_action), 32'd0);

    // Address sequence after the reset, s=7 a=1 s'=0.
    send(7, 1, 0, 1'b0);
    chk("addr_en0", 32'(mem_rd_en), 32'd1);
    chk("addr_0", 32'(mem_addr), 32'd29);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("addr_en_scan", 32'(mem_rd_en), 32'd1);
      chk("addr_scan", 32'(mem_addr), 32'(i));
    end
    @(posedge clk);
    #1;
    chk("addr_en_off", 32'(mem_rd_en), 32'd0);
    chk("addr_off", 32'(mem_addr), 32'd0);
    wait_out("addrseq", 1, 32'hFFFFFFB3, 32'd9, 32'd1);
    handshake("addrseq");

`ifdef Q_FETCH_TERMINAL_EN
    send(9, 3, 4, 1'b1);
    chk("term_addr", 32'(mem_addr), 32'd39);
    wait_out("term", 2, 32'd555, 32'd0, 32'd0);
    chk("term_rd_en", 32'(mem_rd_en), 32'd0);
    handshake("term");
    send(3, 2, 5, 1'b0);
    wait_out("nonterm", 6, 32'd100, 32'd42, 32'd2);
    handshake("nonterm");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
